instr_stream_feeder: RTL and testbench

- Upstream stage of the register-bank/ALU datapath.
- Accepts 13-bit instructions {src1[2:0], src2[2:0], cmd[3:0], dest[2:0]} over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each instruction onto the 3-bit command bus C as a framed burst, with EN marking the frame.
- Inserts a programmable idle gap between frames so the datapath can complete write-back.

---
 rtl/instr_pkg.sv | 33 +++
 rtl/instr_stream_feeder_if.sv | 15 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/instr_stream_feeder.sv | 103 ++++++++++
 tb/tb_instr_stream_feeder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared widths, field positions and FSM encoding for the instruction feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_pkg;

    localparam int INSTR_W = 13;
    localparam int CHUNK_W = 3;
    localparam int BEATS   = 5;
    localparam int FRAME_W = INSTR_W + 2;

    // Field positions inside an instruction word
    localparam int SRC1_MSB = 12;
    localparam int SRC1_LSB = 10;
    localparam int SRC2_MSB = 9;
    localparam int SRC2_LSB = 7;
    localparam int CMD_MSB  = 6;
    localparam int CMD_LSB  = 3;
    localparam int DEST_MSB = 2;
    localparam int DEST_LSB = 0;

    // S_ prefix keeps the GAP literal clear of the feeder's GAP parameter
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } feed_state_t;

    // Pad the instruction to a whole number of 3-bit chunks, MSB-aligned
    function automatic logic [FRAME_W-1:0] frame_of(input logic [INSTR_W-1:0] instr);
        return {instr, 2'b00};
    endfunction

endpackage

// File: rtl/instr_stream_feeder_if.sv
// Valid/ready instruction handshake between a source and the feeder.
// Latency: n/a (wires only).
// Backpressure: source holds in_valid/in_instr stable until in_ready is seen.
interface instr_stream_feeder_if
    import instr_pkg::*;
    ();

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible combinationally.
// Latency: a push is poppable on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_stream_feeder.sv
// Buffers 13-bit instructions and serializes each as a 5-beat 3-bit burst framed by EN.
// Latency: push into empty idle FIFO at edge N -> first EN beat at edge N+2; frames GAP+1 cycles apart.
// Backpressure: in_ready low while FIFO full; hold only blocks starting a new frame.
module instr_stream_feeder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    instr_stream_feeder_if.slave         in_if,
    input  logic                         hold,
    output logic [CHUNK_W-1:0]           C,
    output logic                         EN,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       level,
    output logic [15:0]                  frames_sent
);

    feed_state_t        state;
    logic [2:0]         beat;
    logic [3:0]         gcnt;
    logic [FRAME_W-1:0] shreg;
    logic [15:0]        frames_cnt;
    logic [INSTR_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Readiness comes from registered occupancy only; a same-cycle pop does not open a slot
    assign in_if.in_ready = !full;
    assign push           = in_if.in_valid && in_if.in_ready;
    assign pop            = (state == S_IDLE) && !empty && !hold;
    assign busy           = (level != '0) || (state != S_IDLE);
    assign frames_sent    = frames_cnt;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (in_if.in_instr),
        .pop      (pop),
        .pop_dat  (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    // Frame sequencer: pop in IDLE, shift out 5 chunks in SEND, idle for GAP cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            gcnt       <= '0;
            shreg      <= '0;
            C          <= '0;
            EN         <= 1'b0;
            frames_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    C  <= '0;
                    EN <= 1'b0;
                    if (pop) begin
                        shreg <= frame_of(head);
                        beat  <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    C     <= shreg[FRAME_W-1 -: CHUNK_W];
                    EN    <= 1'b1;
                    shreg <= shreg << CHUNK_W;
                    if (beat == 3'(BEATS - 1)) begin
                        gcnt  <= 4'(GAP - 1);
                        state <= S_GAP;
                    end else begin
                        beat <= beat + 3'd1;
                    end
                end
                S_GAP: begin
                    C  <= '0;
                    EN <= 1'b0;
                    // EN is still high only on the first gap cycle: the frame just ended
                    if (EN) frames_cnt <= frames_cnt + 16'd1;
                    if (gcnt == 4'd0) state <= S_IDLE;
                    else              gcnt  <= gcnt - 4'd1;
                end
                default: begin
                    state <= S_IDLE;
                    C     <= '0;
                    EN    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Directed self-checking bench for instr_stream_feeder.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bench source holds a word until in_ready was high at an edge.
module tb_instr_stream_feeder;

    localparam int DEPTH_P = 4;
    localparam int GAP_P   = 1;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [2:0]  C;
    logic        EN;
    logic        busy;
    logic [2:0]  level;
    logic [15:0] frames_sent;

    int total;
    int bad;

    instr_stream_feeder_if bus ();

    instr_stream_feeder #(
        .DEPTH (DEPTH_P),
        .GAP   (GAP_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (bus),
        .hold        (hold),
        .C           (C),
        .EN          (EN),
        .busy        (busy),
        .level       (level),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Chunk b of the padded frame {w,2'b00}, MSB-first
    function automatic logic [2:0] chunk_of(input logic [12:0] w, input int b);
        logic [14:0] f;
        f = {w, 2'b00};
        return f[14 - 3*b -: 3];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        total++; if (C !== 3'd0)            begin bad++; $display("FAIL rst_C got=%0d exp=0", C); end
        total++; if (EN !== 1'b0)           begin bad++; $display("FAIL rst_EN got=%0b exp=0", EN); end
        total++; if (level !== 3'd0)        begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL rst_frames got=%0d exp=0", frames_sent); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        // Queue one word under hold, then reset mid-cycle
        hold = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 13'h0123;
        cyc();
        bus.in_valid = 1'b0;
        total++; if (level !== 3'd1)        begin bad++; $display("FAIL pre_async_level got=%0d exp=1", level); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (level !== 3'd0)        begin bad++; $display("FAIL async_level got=%0d exp=0", level); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL async_busy got=%0b exp=0", busy); end
        total++; if (EN !== 1'b0 || C !== 3'd0) begin bad++; $display("FAIL async_out got EN=%0b C=%0d exp EN=0 C=0", EN, C); end
        cyc();
        rst = 1'b0;
        hold = 1'b0;
        cyc();
        cyc();
        total++; if (EN !== 1'b0)           begin bad++; $display("FAIL post_rst_no_frame got=%0b exp=0", EN); end
    endtask

    task automatic test_single_frame();
        logic [2:0] exp_c [5];
        logic [15:0] fs0;
        exp_c = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4};
        fs0 = frames_sent;
        bus.in_valid = 1'b1;
        bus.in_instr = 13'b001_010_0110_011;
        cyc();
        bus.in_valid = 1'b0;
        total++; if (level !== 3'd1 || EN !== 1'b0) begin bad++; $display("FAIL single_push got level=%0d EN=%0b exp level=1 EN=0", level, EN); end
        cyc();
        total++; if (EN !== 1'b0 || level !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL single_pop got EN=%0b level=%0d busy=%0b exp 0/0/1", EN, level, busy); end
        for (int b = 0; b < 5; b++) begin
            cyc();
            total++; if (EN !== 1'b1 || C !== exp_c[b]) begin bad++; $display("FAIL single_beat%0d got EN=%0b C=%0d exp EN=1 C=%0d", b, EN, C, exp_c[b]); end
        end
        cyc();
        total++; if (EN !== 1'b0 || C !== 3'd0) begin bad++; $display("FAIL single_end got EN=%0b C=%0d exp EN=0 C=0", EN, C); end
        total++; if (frames_sent !== fs0 + 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=%0d", frames_sent, fs0 + 16'd1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] w [5];
        logic [2:0]  got [5][5];
        int          gaps [5];
        int          nf, nb, lowrun;
        logic        acc;
        logic [15:0] fs0;
        w = '{13'h0123, 13'h1F0F, 13'h0AAA, 13'h1555, 13'h0F31};
        fs0 = frames_sent;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%0b exp=1", i, bus.in_ready); end
            bus.in_valid = 1'b1;
            bus.in_instr = w[i];
            cyc();
        end
        total++; if (level !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full got level=%0d ready=%0b exp level=4 ready=0", level, bus.in_ready); end
        bus.in_instr = w[4];
        cyc();
        cyc();
        cyc();
        total++; if (level !== 3'd4 || bus.in_ready !== 1'b0 || EN !== 1'b0) begin bad++; $display("FAIL full_held got level=%0d ready=%0b EN=%0b exp 4/0/0", level, bus.in_ready, EN); end
        hold = 1'b0;
        nf = 0; nb = 0; lowrun = 0;
        for (int cy = 0; cy < 150 && nf < 5; cy++) begin
            acc = bus.in_valid && bus.in_ready;
            cyc();
            if (acc) bus.in_valid = 1'b0;
            if (EN) begin
                if (nb == 0) gaps[nf] = lowrun;
                got[nf][nb] = C;
                lowrun = 0;
                nb++;
                if (nb == 5) begin nf++; nb = 0; end
            end else begin
                lowrun++;
            end
        end
        total++; if (nf != 5) begin bad++; $display("FAIL b2b_timeout got frames=%0d exp=5", nf); end
        for (int f = 0; f < nf; f++) begin
            for (int b = 0; b < 5; b++) begin
                total++; if (got[f][b] !== chunk_of(w[f], b)) begin bad++; $display("FAIL b2b_f%0d_b%0d got=%0d exp=%0d", f, b, got[f][b], chunk_of(w[f], b)); end
            end
            if (f > 0) begin
                total++; if (gaps[f] != GAP_P + 1) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", f, gaps[f], GAP_P + 1); end
            end
        end
        cyc();
        cyc();
        cyc();
        total++; if (frames_sent !== fs0 + 16'd5) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", frames_sent, fs0 + 16'd5); end
        total++; if (level !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got level=%0d busy=%0b exp 0/0", level, busy); end
    endtask

    task automatic test_hold_mid_frame();
        logic [12:0] wa, wb;
        int en_cnt;
        wa = 13'h1234;
        wb = 13'h0765;
        hold = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = wa;
        cyc();
        bus.in_instr = wb;
        cyc();
        bus.in_valid = 1'b0;
        total++; if (EN !== 1'b0) begin bad++; $display("FAIL hold_pop_cycle got EN=%0b exp=0", EN); end
        for (int b = 0; b < 5; b++) begin
            cyc();
            total++; if (EN !== 1'b1 || C !== chunk_of(wa, b)) begin bad++; $display("FAIL hold_a_b%0d got EN=%0b C=%0d exp EN=1 C=%0d", b, EN, C, chunk_of(wa, b)); end
            if (b == 2) hold = 1'b1;
        end
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (EN) en_cnt++;
        end
        total++; if (en_cnt != 0) begin bad++; $display("FAIL hold_blocks got en_cycles=%0d exp=0", en_cnt); end
        total++; if (level !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL hold_pending got level=%0d busy=%0b exp 1/1", level, busy); end
        hold = 1'b0;
        cyc();
        total++; if (EN !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL hold_release_pop got EN=%0b level=%0d exp 0/0", EN, level); end
        for (int b = 0; b < 5; b++) begin
            cyc();
            total++; if (EN !== 1'b1 || C !== chunk_of(wb, b)) begin bad++; $display("FAIL hold_b_b%0d got EN=%0b C=%0d exp EN=1 C=%0d", b, EN, C, chunk_of(wb, b)); end
        end
        cyc();
        cyc();
        total++; if (busy !== 1'b0 || EN !== 1'b0) begin bad++; $display("FAIL hold_end got busy=%0b EN=%0b exp 0/0", busy, EN); end
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] w [3];
        int en_cnt;
        w = '{13'h1111, 13'h0222, 13'h1333};
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = w[i];
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        total++; if (EN !== 1'b1 || C !== chunk_of(w[0], 3) || level !== 3'd2) begin bad++; $display("FAIL rmid_beat3 got EN=%0b C=%0d level=%0d exp 1/%0d/2", EN, C, level, chunk_of(w[0], 3)); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (EN !== 1'b0 || C !== 3'd0) begin bad++; $display("FAIL rmid_abort got EN=%0b C=%0d exp 0/0", EN, C); end
        total++; if (level !== 3'd0 || frames_sent !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_state got level=%0d frames=%0d busy=%0b exp 0/0/0", level, frames_sent, busy); end
        cyc();
        cyc();
        rst = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (EN) en_cnt++;
        end
        total++; if (en_cnt != 0 || level !== 3'd0) begin bad++; $display("FAIL rmid_quiet got en_cycles=%0d level=%0d exp 0/0", en_cnt, level); end
    endtask

    task automatic test_counter_wrap();
        int en_cnt;
        logic done;
        force dut.frames_cnt = 16'hFFFF;
        cyc();
        release dut.frames_cnt;
        cyc();
        total++; if (frames_sent !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%0h exp=ffff", frames_sent); end
        bus.in_valid = 1'b1;
        bus.in_instr = 13'h1ACE;
        cyc();
        bus.in_valid = 1'b0;
        en_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc();
            if (EN) en_cnt++;
            else if (en_cnt > 0) done = 1'b1;
        end
        total++; if (!done || en_cnt != 5) begin bad++; $display("FAIL wrap_frame got done=%0b beats=%0d exp 1/5", done, en_cnt); end
        total++; if (frames_sent !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%0h exp=0", frames_sent); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        clk = 1'b0;
        rst = 1'b1;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_mid_frame();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
